// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive controller: FSM state encoding and parity-type codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        OUT    = 3'd5
    } rx_state_t;

    // PAR_TYP encodings
    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    // Expected parity bit given the XOR of the data bits and the parity type.
    function automatic logic par_expect(input logic data_xor, input logic typ);
        return data_xor ^ (typ == ODD);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Mid-bit oversampler: captures two samples around the bit centre and votes with a third.
// Latency: decision is combinational at Edge_Cnt==H+1 using samples taken at H-1 and H.
// Backpressure: none; follows the external edge counter every cycle.
// Ports: CLK/RST (sync, active-low); RX_IN serial line; PRESCALE oversampling ratio;
//        Edge_Cnt edge index within bit; dec_vld decision strobe; dec_dat voted bit value.
module uart_rx_sampler (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic [5:0] PRESCALE,
    input  logic [5:0] Edge_Cnt,
    output logic       dec_vld,
    output logic       dec_dat
);

    logic [5:0] half;
    logic       s0;
    logic       s1;

    assign half = PRESCALE >> 1;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            if (Edge_Cnt == half - 6'd1) s0 <= RX_IN;
            if (Edge_Cnt == half)        s1 <= RX_IN;
        end
    end

    // Third vote is the live line one edge after s1, so a single-cycle glitch is outvoted.
    assign dec_vld = (Edge_Cnt == half + 6'd1);
    assign dec_dat = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, LSB-first shifter, parity and stop checks.
// Latency: result pulses one cycle after the stop-bit decision point (the OUT state).
// Backpressure: none; Data_Valid/Par_Err/Stp_Err are single-cycle pulses that must be taken.
// Ports: CLK/RST (sync, active-low); RX_IN line; PRESCALE, PAR_EN, PAR_TYP frame config;
//        Edge_Cnt/Bit_Cnt from the external counter; Cnt_En enables it; P_DATA last good word;
//        Data_Valid, Par_Err, Stp_Err result pulses.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Edge_Cnt,
    input  logic [3:0]            Bit_Cnt,
    output logic                  Cnt_En,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err
);

    rx_state_t             state;
    rx_state_t             state_nxt;
    logic                  dec_vld;
    logic                  dec_dat;
    logic                  eob;
    logic                  start_entry;
    logic                  par_en_q;
    logic                  par_flag;
    logic                  stp_flag;
    logic [DATA_WIDTH-1:0] shift_dat;
    logic                  dv_nxt;
    logic                  pe_nxt;
    logic                  se_nxt;

    uart_rx_sampler u_sampler (
        .CLK      (CLK),
        .RST      (RST),
        .RX_IN    (RX_IN),
        .PRESCALE (PRESCALE),
        .Edge_Cnt (Edge_Cnt),
        .dec_vld  (dec_vld),
        .dec_dat  (dec_dat)
    );

    assign eob         = (Edge_Cnt == PRESCALE - 6'd1);
    assign start_entry = (state == IDLE) && !RX_IN;

    // State register
    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic. In START the glitch check wins over end-of-bit, which matters
    // at PRESCALE=4 where the decision point and end-of-bit coincide.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!RX_IN) state_nxt = START;
            START: begin
                if (dec_vld && dec_dat)           state_nxt = IDLE;
                else if (eob && Bit_Cnt == 4'd0)  state_nxt = DATA;
            end
            DATA:    if (eob && Bit_Cnt == 4'(DATA_WIDTH))
                         state_nxt = par_en_q ? PARITY : STOP;
            PARITY:  if (eob) state_nxt = STOP;
            STOP:    if (dec_vld) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode. The stop bit is judged from the live decision since the flag
    // register only updates on the same edge the pulses are launched.
    always_comb begin
        Cnt_En = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
        pe_nxt = (state == STOP) && dec_vld && par_flag;
        se_nxt = (state == STOP) && dec_vld && (!dec_dat || stp_flag);
        dv_nxt = (state == STOP) && dec_vld && !pe_nxt && !se_nxt;
    end

    // Datapath: config capture, shifter, error flags, registered result pulses.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            par_en_q   <= 1'b0;
            shift_dat  <= '0;
            par_flag   <= 1'b0;
            stp_flag   <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
        end else begin
            if (dec_vld) par_en_q <= PAR_EN;

            if (state == DATA && dec_vld)
                shift_dat <= {dec_dat, shift_dat[DATA_WIDTH-1:1]};

            if (start_entry) begin
                par_flag <= 1'b0;
                stp_flag <= 1'b0;
            end else begin
                if (state == PARITY && dec_vld &&
                    dec_dat != par_expect(^shift_dat, PAR_TYP))
                    par_flag <= 1'b1;
                if (state == STOP && dec_vld && !dec_dat)
                    stp_flag <= 1'b1;
            end

            Data_Valid <= dv_nxt;
            Par_Err    <= pe_nxt;
            Stp_Err    <= se_nxt;
            if (dv_nxt) P_DATA <= shift_dat;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: models the edge/bit counter, drives frames keyed to it,
// and scores result pulses against a queue of expected outcomes.
// Ports: none (top-level bench).
module tb_uart_rx_ctrl;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic [5:0] PRESCALE;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Edge_Cnt;
    logic [3:0] Bit_Cnt;
    logic       Cnt_En;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_Err;
    logic       Stp_Err;

    int checks = 0;
    int errors = 0;
    int npulse = 0;
    int nexp   = 0;

    typedef struct packed {
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] dat;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] last_good;

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Edge_Cnt   (Edge_Cnt),
        .Bit_Cnt    (Bit_Cnt),
        .Cnt_En     (Cnt_En),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stp_Err    (Stp_Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Neighbouring counter stage: clears while disabled, wraps edges at PRESCALE-1.
    always @(posedge CLK) begin
        if (!RST || !Cnt_En) begin
            Edge_Cnt <= 6'd0;
            Bit_Cnt  <= 4'd0;
        end else if (Edge_Cnt == PRESCALE - 6'd1) begin
            Edge_Cnt <= 6'd0;
            Bit_Cnt  <= Bit_Cnt + 4'd1;
        end else begin
            Edge_Cnt <= Edge_Cnt + 6'd1;
        end
    end

    // Scoreboard consumer: every cycle with a result pulse pops one expectation.
    always @(negedge CLK) begin
        if (RST === 1'b1 && (Data_Valid === 1'b1 || Par_Err === 1'b1 || Stp_Err === 1'b1)) begin
            npulse++;
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {29'd0, Data_Valid, Par_Err, Stp_Err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("data_valid", {31'd0, Data_Valid}, {31'd0, mon_e.dv});
                chk("par_err",    {31'd0, Par_Err},    {31'd0, mon_e.pe});
                chk("stp_err",    {31'd0, Stp_Err},    {31'd0, mon_e.se});
                chk("p_data",     {24'd0, P_DATA},     {24'd0, mon_e.dat});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic logic good_par(input logic [7:0] d, input logic typ);
        return (^d) ^ typ;
    endfunction

    // Drives one frame with every bit value keyed to the counter model.
    // glitch_bc/glitch_ec flip the line for one cycle; rst_bc>=0 pulses reset at that bit.
    task automatic send_frame(input logic [5:0] ps, input logic [7:0] d, input logic pen,
                              input logic ptyp, input logic pbit, input logic stp,
                              input int glitch_bc, input int glitch_ec, input int rst_bc);
        logic [15:0] bits;
        int          stop_idx;
        int          cyc;
        logic        seen_stop;
        logic        done;
        logic        v;
        exp_t        e;
        bits     = 16'hFFFF;
        bits[0]  = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        stop_idx = pen ? 10 : 9;
        if (pen) bits[9] = pbit;
        bits[stop_idx] = stp;
        PRESCALE = ps;
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        if (rst_bc < 0) begin
            e.pe  = pen && (pbit != ((^d) ^ ptyp));
            e.se  = !stp;
            e.dv  = !e.pe && !e.se;
            e.dat = e.dv ? d : last_good;
            if (e.dv) last_good = d;
            sb.push_back(e);
            nexp++;
        end
        seen_stop = 1'b0;
        done      = 1'b0;
        cyc       = 0;
        while (!done) begin
            v = bits[Bit_Cnt];
            if (Cnt_En && int'(Bit_Cnt) == glitch_bc && int'(Edge_Cnt) == glitch_ec) v = ~v;
            if (rst_bc >= 0 && Cnt_En && int'(Bit_Cnt) == rst_bc && Edge_Cnt == 6'd0) begin
                RX_IN = v;
                RST   = 1'b0;
                @(posedge CLK); #1;
                chk("rst_cnt_en",     {31'd0, Cnt_En},     32'd0);
                chk("rst_p_data",     {24'd0, P_DATA},     32'd0);
                chk("rst_data_valid", {31'd0, Data_Valid}, 32'd0);
                chk("rst_par_err",    {31'd0, Par_Err},    32'd0);
                chk("rst_stp_err",    {31'd0, Stp_Err},    32'd0);
                RST       = 1'b1;
                RX_IN     = 1'b1;
                last_good = 8'h00;
                return;
            end
            RX_IN = v;
            @(posedge CLK); #1;
            cyc++;
            if (int'(Bit_Cnt) == stop_idx) seen_stop = 1'b1;
            if (seen_stop && Bit_Cnt == 4'd0) done = 1'b1;
            if (cyc > 2000) begin
                chk("frame_timeout", cyc, 32'd0);
                done = 1'b1;
            end
        end
        RX_IN = 1'b1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        int last_ec;
        int guard;
        RST       = 1'b0;
        RX_IN     = 1'b1;
        PRESCALE  = 6'd8;
        PAR_EN    = 1'b0;
        PAR_TYP   = 1'b0;
        last_good = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_cnt_en",     {31'd0, Cnt_En},     32'd0);
        chk("reset_p_data",     {24'd0, P_DATA},     32'd0);
        chk("reset_data_valid", {31'd0, Data_Valid}, 32'd0);
        chk("reset_par_err",    {31'd0, Par_Err},    32'd0);
        chk("reset_stp_err",    {31'd0, Stp_Err},    32'd0);
        RST = 1'b1;
        idle(5);
        chk("idle_line_high_cnt_en", {31'd0, Cnt_En}, 32'd0);

        // Good even-parity frame
        send_frame(6'd8, 8'hA5, 1'b1, 1'b0, good_par(8'hA5, 1'b0), 1'b1, -1, -1, -1);
        idle(3);
        // Odd parity expected 1, sent 0: parity error, P_DATA holds 0xA5
        send_frame(6'd16, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, -1, -1, -1);
        idle(3);
        // No parity, stop bit low
        send_frame(6'd8, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1);
        idle(3);
        // Parity and stop errors together
        send_frame(6'd8, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1, -1);
        idle(3);

        // Short low pulse on an idle line is rejected at the start-bit decision
        PRESCALE = 6'd16;
        RX_IN = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RX_IN   = 1'b1;
        last_ec = -1;
        guard   = 0;
        while (Cnt_En === 1'b1 && guard < 100) begin
            last_ec = int'(Edge_Cnt);
            @(posedge CLK); #1;
            guard++;
        end
        chk("false_start_edge", last_ec, 32'd9);
        chk("false_start_cnt_en", {31'd0, Cnt_En}, 32'd0);
        idle(20);
        chk("false_start_still_idle", {31'd0, Cnt_En}, 32'd0);

        // Back-to-back at PRESCALE=4 with a one-cycle glitch on data bit 3 of the second frame
        send_frame(6'd4, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, -1);
        send_frame(6'd4, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 4, 2, -1);
        idle(3);

        // Widest ratio, good odd-parity frame
        send_frame(6'd32, 8'h96, 1'b1, 1'b1, good_par(8'h96, 1'b1), 1'b1, -1, -1, -1);
        idle(3);

        // Reset mid-frame, then a clean frame
        send_frame(6'd8, 8'h3C, 1'b1, 1'b0, good_par(8'h3C, 1'b0), 1'b1, -1, -1, 4);
        idle(5);
        chk("post_rst_cnt_en", {31'd0, Cnt_En}, 32'd0);
        send_frame(6'd8, 8'h81, 1'b1, 1'b0, good_par(8'h81, 1'b0), 1'b1, -1, -1, -1);
        idle(5);

        chk("scoreboard_empty", sb.size(), 32'd0);
        chk("pulse_count", npulse, nexp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
